// File: rtl/dma_rd_sched.sv
// Purpose: round-robin arbiter that hands the DRAM read plane to one of three clients
//          (0 = ifmap, 1 = weight, 2 = bias/aux) and latches that client's stream parameters.
// Latency: i_req sampled at edge t -> o_rd_start in cycle t+1; o_done one cycle after i_ctrl_read_done.
// Backpressure: one stream in flight at a time; a client holds i_req until its o_done pulse.
// Ports: clk/rstn (sync active-low reset); i_req, i_base_addr, i_num_trans, i_max_blk (per-client
//        slices); o_grant, o_done (per client); o_rd_start, o_rd_* (to read-plane controller);
//        i_ctrl_read_done (from controller); o_busy, o_timeout (sticky watchdog), i_clr_err.
module dma_rd_sched #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int BIT_TRANS    = 18,
  parameter int TIMEOUT_CYC  = 1048576
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [2:0]                i_req,
  input  logic [3*AXI_WIDTH_AD-1:0] i_base_addr,
  input  logic [3*BIT_TRANS-1:0]    i_num_trans,
  input  logic [3*16-1:0]           i_max_blk,
  output logic [2:0]                o_grant,
  output logic [2:0]                o_done,
  output logic                      o_rd_start,
  output logic [AXI_WIDTH_AD-1:0]   o_rd_base_addr,
  output logic [BIT_TRANS-1:0]      o_rd_num_trans,
  output logic [15:0]               o_rd_max_req_blk_idx,
  input  logic                      i_ctrl_read_done,
  output logic                      o_busy,
  output logic                      o_timeout,
  input  logic                      i_clr_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  // Counter is one bit wider than needed to reach TIMEOUT_CYC-1 so it can park
  // one past the trip point; that makes the timeout a single set event, which
  // lets i_clr_err clear the flag even while the FSM is still stuck in BUSY.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WD_TRIP = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] WD_PARK = CW'(TIMEOUT_CYC);

  state_t                    state, state_nxt;
  logic [1:0]                last;
  logic [1:0]                win_q;
  logic [CW-1:0]             wd_cnt;

  logic [1:0]                cand0, cand1, win;
  logic [AXI_WIDTH_AD-1:0]   sel_base;
  logic [BIT_TRANS-1:0]      sel_num;
  logic [15:0]               sel_blk;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Priority order last+1, last+2, last (mod 3).
  always_comb begin
    cand0 = inc3(last);
    cand1 = inc3(cand0);
    win   = last;
    if (i_req[cand0])      win = cand0;
    else if (i_req[cand1]) win = cand1;
  end

  always_comb begin
    sel_base = i_base_addr[0 +: AXI_WIDTH_AD];
    sel_num  = i_num_trans[0 +: BIT_TRANS];
    sel_blk  = i_max_blk[0 +: 16];
    case (win)
      2'd1: begin
        sel_base = i_base_addr[AXI_WIDTH_AD +: AXI_WIDTH_AD];
        sel_num  = i_num_trans[BIT_TRANS +: BIT_TRANS];
        sel_blk  = i_max_blk[16 +: 16];
      end
      2'd2: begin
        sel_base = i_base_addr[2*AXI_WIDTH_AD +: AXI_WIDTH_AD];
        sel_num  = i_num_trans[2*BIT_TRANS +: BIT_TRANS];
        sel_blk  = i_max_blk[32 +: 16];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A zero-block stream never reaches the controller, which would
        // underflow computing max-1.
        if (|i_req) state_nxt = (sel_blk == 16'd0) ? DONE : LAUNCH;
      end
      LAUNCH:  state_nxt = BUSY;
      BUSY:    if (i_ctrl_read_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                <= IDLE;
      last                 <= 2'd2;
      win_q                <= 2'd0;
      o_grant              <= 3'b000;
      o_rd_base_addr       <= '0;
      o_rd_num_trans       <= '0;
      o_rd_max_req_blk_idx <= '0;
      wd_cnt               <= '0;
      o_timeout            <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && |i_req) begin
        win_q                <= win;
        o_grant              <= 3'b001 << win;
        o_rd_base_addr       <= sel_base;
        o_rd_num_trans       <= sel_num;
        o_rd_max_req_blk_idx <= sel_blk;
      end

      if (state == DONE) begin
        o_grant <= 3'b000;
        last    <= win_q;
      end

      if (state == LAUNCH)
        wd_cnt <= '0;
      else if (state == BUSY && wd_cnt != WD_PARK)
        wd_cnt <= wd_cnt + 1'b1;

      // Set wins over a simultaneous clear.
      if (state == BUSY && wd_cnt == WD_TRIP)
        o_timeout <= 1'b1;
      else if (i_clr_err)
        o_timeout <= 1'b0;
    end
  end

  assign o_rd_start = (state == LAUNCH);
  assign o_done     = (state == DONE) ? o_grant : 3'b000;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_dma_rd_sched.sv
module tb_dma_rd_sched;
  localparam int AW = 32;
  localparam int BT = 18;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    i_req;
  logic [3*AW-1:0] i_base_addr;
  logic [3*BT-1:0] i_num_trans;
  logic [47:0]   i_max_blk;
  logic [2:0]    o_grant, o_done;
  logic          o_rd_start;
  logic [AW-1:0] o_rd_base_addr;
  logic [BT-1:0] o_rd_num_trans;
  logic [15:0]   o_rd_max_req_blk_idx;
  logic          i_ctrl_read_done;
  logic          o_busy, o_timeout, i_clr_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int prev_start;

  dma_rd_sched #(.AXI_WIDTH_AD(AW), .BIT_TRANS(BT), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_base_addr(i_base_addr),
    .i_num_trans(i_num_trans), .i_max_blk(i_max_blk), .o_grant(o_grant),
    .o_done(o_done), .o_rd_start(o_rd_start), .o_rd_base_addr(o_rd_base_addr),
    .o_rd_num_trans(o_rd_num_trans), .o_rd_max_req_blk_idx(o_rd_max_req_blk_idx),
    .i_ctrl_read_done(i_ctrl_read_done), .o_busy(o_busy), .o_timeout(o_timeout),
    .i_clr_err(i_clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn = 1'b0; i_req = 3'b000; i_base_addr = '0; i_num_trans = '0; i_max_blk = '0;
    i_ctrl_read_done = 1'b0; i_clr_err = 1'b0;
    tick(2);
    chk("rst_grant", o_grant, 3'b000);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_start", o_rd_start, 1'b0);
    chk("rst_done", o_done, 3'b000);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_base", o_rd_base_addr, 32'h0);
    rstn = 1'b1;
    tick();

    // Single request on client 0.
    i_base_addr[0 +: AW] = 32'h1000_0000;
    i_num_trans[0 +: BT] = 18'd16;
    i_max_blk[0 +: 16]   = 16'd4;
    i_req = 3'b001;
    tick();
    chk("single_start", o_rd_start, 1'b1);
    chk("single_grant", o_grant, 3'b001);
    chk("single_base", o_rd_base_addr, 32'h1000_0000);
    chk("single_num", o_rd_num_trans, 18'd16);
    chk("single_blk", o_rd_max_req_blk_idx, 16'd4);
    chk("single_busy", o_busy, 1'b1);
    tick();
    chk("single_start_1cyc", o_rd_start, 1'b0);
    tick(4);
    chk("single_no_done_yet", o_done, 3'b000);
    i_ctrl_read_done = 1'b1;
    tick();
    i_ctrl_read_done = 1'b0;
    chk("single_done", o_done, 3'b001);
    i_req = 3'b000;
    tick();
    chk("single_done_1cyc", o_done, 3'b000);
    chk("single_grant_clr", o_grant, 3'b000);
    chk("single_idle", o_busy, 1'b0);

    // Done strobe outside BUSY must be ignored.
    i_ctrl_read_done = 1'b1;
    tick();
    i_ctrl_read_done = 1'b0;
    chk("stray_done_busy", o_busy, 1'b0);
    chk("stray_done_out", o_done, 3'b000);

    // Fairness from reset: order 0,1,2,0,1,2 at 4-cycle spacing.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_base_addr[k*AW +: AW] = 32'h2000_0000 + 32'(k * 256);
      i_max_blk[k*16 +: 16]   = 16'd3;
    end
    i_req = 3'b111;
    prev_start = 0;
    for (int r = 0; r < 6; r++) begin
      tick();
      chk($sformatf("rr%0d_start", r), o_rd_start, 1'b1);
      chk($sformatf("rr%0d_grant", r), o_grant, 3'b001 << (r % 3));
      chk($sformatf("rr%0d_base", r), o_rd_base_addr, 32'h2000_0000 + 32'((r % 3) * 256));
      if (r > 0) chk($sformatf("rr%0d_spacing", r), cyc - prev_start, 4);
      prev_start = cyc;
      tick();
      i_ctrl_read_done = 1'b1;
      tick();
      i_ctrl_read_done = 1'b0;
      chk($sformatf("rr%0d_done", r), o_done, 3'b001 << (r % 3));
      if (r == 5) i_req = 3'b000;
      tick();
      chk($sformatf("rr%0d_idle_start", r), o_rd_start, 1'b0);
    end

    // Zero blocks on client 1: straight to DONE, no read start.
    i_max_blk[16 +: 16] = 16'd0;
    i_req = 3'b010;
    tick();
    chk("zero_done", o_done, 3'b010);
    chk("zero_nostart", o_rd_start, 1'b0);
    i_req = 3'b000;
    tick();
    chk("zero_idle_start", o_rd_start, 1'b0);
    chk("zero_idle", o_busy, 1'b0);

    // Parameter stability across BUSY.
    i_base_addr[0 +: AW] = 32'hA000_0000;
    i_num_trans[0 +: BT] = 18'd16;
    i_max_blk[0 +: 16]   = 16'd4;
    i_req = 3'b001;
    tick(2);
    i_base_addr[0 +: AW] = 32'hBBBB_0000;
    i_num_trans[0 +: BT] = 18'd99;
    tick();
    chk("stable_base", o_rd_base_addr, 32'hA000_0000);
    chk("stable_num", o_rd_num_trans, 18'd16);
    i_ctrl_read_done = 1'b1;
    tick();
    i_ctrl_read_done = 1'b0;
    chk("stable_done", o_done, 3'b001);
    chk("stable_base_done", o_rd_base_addr, 32'hA000_0000);
    i_req = 3'b000;
    tick();

    // Watchdog with TIMEOUT_CYC = 8.
    i_req = 3'b001;
    tick(2);
    tick(7);
    chk("wd_before", o_timeout, 1'b0);
    tick();
    chk("wd_set", o_timeout, 1'b1);
    chk("wd_still_busy", o_busy, 1'b1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("wd_clr", o_timeout, 1'b0);
    tick(2);
    chk("wd_stays_clr", o_timeout, 1'b0);
    i_ctrl_read_done = 1'b1;
    tick();
    i_ctrl_read_done = 1'b0;
    chk("wd_late_done", o_done, 3'b001);
    i_req = 3'b000;
    tick();

    // Done and watchdog trip in the same cycle.
    i_req = 3'b001;
    tick(2);
    tick(7);
    i_ctrl_read_done = 1'b1;
    tick();
    i_ctrl_read_done = 1'b0;
    chk("both_done", o_done, 3'b001);
    chk("both_timeout", o_timeout, 1'b1);
    i_req = 3'b000;
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;

    // Reset mid-BUSY on client 1, then re-arbitration starts at client 0.
    i_max_blk[16 +: 16] = 16'd2;
    i_req = 3'b010;
    tick(2);
    chk("mid_grant_pre", o_grant, 3'b010);
    rstn = 1'b0;
    tick();
    chk("mid_rst_grant", o_grant, 3'b000);
    chk("mid_rst_done", o_done, 3'b000);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_base", o_rd_base_addr, 32'h0);
    rstn = 1'b1;
    i_req = 3'b011;
    tick();
    chk("mid_restart_grant", o_grant, 3'b001);
    chk("mid_restart_start", o_rd_start, 1'b1);
    i_req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dma_rd_sched.md
DMA_RD_SCHED -- requirements
Module: dma_rd_sched

Interface
REQ-001 SHALL have parameter AXI_WIDTH_AD, default 32, DRAM address width.
REQ-002 SHALL have parameter BIT_TRANS, default 18, per-block transfer-count width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1048576, BUSY-state watchdog limit in cycles.
REQ-004 SHALL have one clock and synchronous, active-low reset: clk input 1, rising-edge clock; rstn input 1, synchronous active-low reset.
REQ-005 SHALL have i_req input 3, level request per client (0 = ifmap, 1 = weight, 2 = bias/aux).
REQ-006 SHALL have i_base_addr input 3*AXI_WIDTH_AD, per-client base address; client k occupies slice k.
REQ-007 SHALL have i_num_trans input 3*BIT_TRANS, per-client transfers per block.
REQ-008 SHALL have i_max_blk input 3*16, per-client block count.
REQ-009 SHALL have o_grant output 3, one-hot owner of the read plane.
REQ-010 SHALL have o_done output 3, one-cycle completion pulse per client.
REQ-011 SHALL have o_rd_start output 1, one-cycle read-stream start to the read-plane controller.
REQ-012 SHALL have o_rd_base_addr output AXI_WIDTH_AD, latched base address for the controller.
REQ-013 SHALL have o_rd_num_trans output BIT_TRANS, latched transfer count.
REQ-014 SHALL have o_rd_max_req_blk_idx output 16, latched block count.
REQ-015 SHALL have i_ctrl_read_done input 1, one-cycle stream-done from the controller.
REQ-016 SHALL have o_busy output 1, high in any state other than IDLE.
REQ-017 SHALL have o_timeout output 1, sticky watchdog flag.
REQ-018 SHALL have i_clr_err input 1, clears o_timeout.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, BUSY, DONE.
REQ-020 SHALL, in IDLE with any i_req bit high, pick winner k by round-robin and move to LAUNCH; at that edge it latches the slice-k parameters into the o_rd_* registers and sets o_grant to one-hot k.
REQ-021 SHALL use round-robin priority order (last+1, last+2, last) mod 3; `last` resets to 2, so client 0 has highest priority after reset.
REQ-022 SHALL update `last` to k on leaving DONE.
REQ-023 SHALL, when winner's i_max_blk == 0, go IDLE -> DONE directly (no o_rd_start), avoiding controller underflow on max-1.
REQ-024 SHALL assert o_rd_start for exactly the single LAUNCH cycle, then move to BUSY; latency is i_req sampled at edge t -> o_rd_start high in cycle t+1.
REQ-025 SHALL, in BUSY, move to DONE on i_ctrl_read_done.
REQ-026 SHALL assert o_done[k] for exactly the single DONE cycle, then return to IDLE; o_grant clears on entering IDLE.
REQ-027 SHALL ignore i_ctrl_read_done outside BUSY.
REQ-028 SHALL NOT re-arbitrate before IDLE; minimum spacing between successive o_rd_start pulses is 4 cycles.
REQ-029 SHALL hold o_rd_* registers stable from LAUNCH through DONE; client input changes after the grant have no effect.
REQ-030 SHALL require the client to hold i_req until o_done[k]; a request still high in the IDLE cycle after DONE is treated as a new request.
REQ-031 SHALL clear the watchdog counter on BUSY entry and increment it each BUSY cycle; reaching TIMEOUT_CYC-1 sets o_timeout, while the FSM stays in BUSY.
REQ-032 SHALL let i_clr_err clear o_timeout in the following cycle; a simultaneous set and clear resolves to set.
REQ-033 SHALL give i_ctrl_read_done priority over the watchdog when both occur in the same cycle: the FSM moves to DONE and o_timeout is still set.

Reset
REQ-034 SHALL, with rstn low at a rising edge, set state=IDLE, last=2, and all outputs, o_rd_* and watchdog to 0, regardless of state.
REQ-035 SHALL drop any grant in flight on reset without issuing o_done; requesters re-arbitrate from IDLE after reset.

Verification
REQ-036 Single request: i_req=3'b001, base 0x1000_0000, num_trans 16, max_blk 4 -> o_rd_start one cycle after sampling; o_rd_base_addr=0x1000_0000; done pulse 5 cycles later -> o_done=3'b001 one cycle later.
REQ-037 Fairness: i_req=3'b111 held continuously -> grant order 0,1,2,0,1,2, with each o_rd_start at least 4 cycles apart.
REQ-038 Zero blocks: i_req=3'b010, max_blk=0 -> o_done=3'b010 one cycle after sampling; o_rd_start never asserted.
REQ-039 Parameter stability: client 0's i_base_addr changes during BUSY -> o_rd_base_addr unchanged until DONE.
REQ-040 Watchdog: TIMEOUT_CYC=8, no done -> o_timeout=1 after the 8th BUSY cycle; i_clr_err -> 0; a later done still produces o_done.
REQ-041 Reset mid-BUSY: rstn low one cycle -> all outputs 0, no o_done, then grant restarts at client 0.
